// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: takes 16 message words per block and
// streams W[0..63] through a registered valid/ready output.
module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        busy
);

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t      state;
  logic [5:0]  t;
  logic [31:0] wbuf [16];

  logic        adv;
  logic        acc;
  logic        step_exp;
  logic [3:0]  i2;
  logic [3:0]  i7;
  logic [3:0]  i15;
  logic [3:0]  i16;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'b0, x[31:10]};
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state == LOAD) && adv && !clear && !rst;
  assign acc      = in_valid && in_ready;
  assign step_exp = (state == EXPAND) && adv && !clear && !rst;
  assign busy     = (state == EXPAND) || out_valid;

  // Ring positions of W[t-k]; t-16 and t share a slot.
  assign i2  = t[3:0] - 4'd2;
  assign i7  = t[3:0] - 4'd7;
  assign i15 = t[3:0] + 4'd1;
  assign i16 = t[3:0];

  assign w_new = sig1(wbuf[i2]) + wbuf[i7]
               + sig0(wbuf[i15]) + wbuf[i16];

  always_ff @(posedge clk) begin
    if (acc) begin
      wbuf[t[3:0]] <= in_data;
    end else if (step_exp) begin
      wbuf[t[3:0]] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      t         <= 6'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_idx   <= 6'd0;
    end else if (clear) begin
      state     <= LOAD;
      t         <= 6'd0;
      out_valid <= 1'b0;
    end else if (adv) begin
      unique case (state)
        LOAD: begin
          if (acc) begin
            out_data  <= in_data;
            out_idx   <= t;
            out_valid <= 1'b1;
            t         <= t + 6'd1;
            if (t == 6'd15) state <= EXPAND;
          end else begin
            out_valid <= 1'b0;
          end
        end
        EXPAND: begin
          out_data  <= w_new;
          out_idx   <= t;
          out_valid <= 1'b1;
          t         <= t + 6'd1;
          if (t == 6'd63) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched against an array-based
// FIPS 180-4 schedule model and an in-order output scoreboard.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        busy;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [31:0] inq  [$];
  logic [31:0] expd [$];
  logic [5:0]  expi [$];
  logic [31:0] blk  [16];
  logic [31:0] seen [64];
  logic        held;
  logic [31:0] hdata;
  logic [5:0]  hidx;
  int          n;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_blk();
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = s1(w[i-2]) + w[i-7]
                + s0(w[i-15]) + w[i-16];
      expd.push_back(w[i]);
      expi.push_back(6'(i));
    end
    for (int i = 0; i < 16; i++) inq.push_back(blk[i]);
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic flush();
    inq.delete();
    expd.delete();
    expi.delete();
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input logic iv, input logic ordy);
    logic acc;
    logic cons;
    in_valid  = iv;
    in_data   = (inq.size() > 0) ? inq[0] : $urandom;
    out_ready = ordy;
    #1;
    if (held && !rst && !clear) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hdata);
      chk("hold_idx", out_idx, hidx);
    end
    acc   = in_valid && in_ready;
    cons  = out_valid && out_ready && !rst && !clear;
    held  = out_valid && !out_ready && !rst && !clear;
    hdata = out_data;
    hidx  = out_idx;
    if (acc && inq.size() > 0) void'(inq.pop_front());
    if (cons) begin
      if (expd.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        chk("out_idx", out_idx, expi[0]);
        chk("out_data", out_data, expd[0]);
        seen[out_idx] = out_data;
        void'(expd.pop_front());
        void'(expi.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int max, output int cnt);
    cnt = 0;
    while (expd.size() > 0 && cnt < max) begin
      step(inq.size() > 0, 1'b1);
      cnt++;
    end
    if (expd.size() > 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_to(input logic [5:0] idx);
    int k = 0;
    while (!(out_valid && out_idx == idx) && k < 200) begin
      step(inq.size() > 0, 1'b1);
      k++;
    end
    chk("reach_idx", out_idx, idx);
  endtask

  task automatic abc_blk();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    held      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);

    // "abc" block, streaming
    abc_blk();
    push_blk();
    drain(200, n);
    chk("abc_w16", seen[16], 32'h61626380);
    chk("abc_w17", seen[17], 32'h000F0000);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // backpressure at W20
    rand_blk();
    push_blk();
    run_to(6'd20);
    repeat (5) step(1'b0, 1'b0);
    drain(200, n);

    // input gaps on the abc block
    abc_blk();
    push_blk();
    n = 0;
    while (inq.size() > 0 && n < 300) begin
      logic iv;
      iv = 1'($urandom_range(0, 1));
      step(iv, 1'b1);
      if (!iv && inq.size() > 0) chk("gap_idle", out_valid, 0);
      n++;
    end
    drain(200, n);
    chk("gap_w16", seen[16], 32'h61626380);
    chk("gap_w17", seen[17], 32'h000F0000);

    // two blocks back-to-back
    rand_blk();
    push_blk();
    rand_blk();
    push_blk();
    drain(400, n);
    chk("b2b_cycles", n, 129);

    // clear at W40 with a concurrent in_valid
    rand_blk();
    push_blk();
    run_to(6'd40);
    flush();
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 0);
    step(1'b1, 1'b1);
    clear = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    rand_blk();
    push_blk();
    drain(200, n);

    // reset during expansion
    rand_blk();
    push_blk();
    run_to(6'd30);
    flush();
    rst = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 0);
    step(1'b0, 1'b1);
    rst = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_out_idx", out_idx, 0);
    chk("rst2_busy", busy, 0);
    rand_blk();
    push_blk();
    drain(200, n);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 Parameter: none; block size fixed at 16 input words, 64 output words (FIPS 180-4 SHA-256).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: clear  input  1  synchronous abort of current block.
REQ-005 Port: in_valid  input  1  in_data holds a message word.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: in_data  input  32  message word M[t], big-endian word as in FIPS 180-4.
REQ-008 Port: out_valid  output  1  out_data/out_idx hold a schedule word.
REQ-009 Port: out_ready  input  1  consumer takes the output word this cycle.
REQ-010 Port: out_data  output  32  schedule word W[out_idx].
REQ-011 Port: out_idx  output  6  index t of W[t], 0..63.
REQ-012 Port: busy  output  1  high while in EXPAND or out_valid=1.

Function
REQ-013 Internal state: 16x32 circular buffer buf, 6-bit counter t, state in {LOAD, EXPAND}, registered output (out_valid, out_data, out_idx).
REQ-014 adv = !out_valid | out_ready; output register loads only when adv=1; otherwise out_valid/out_data/out_idx hold unchanged.
REQ-015 LOAD (t 0..15): in_ready = adv (combinational); on in_valid & in_ready: buf[t[3:0]] <= in_data, out_data <= in_data, out_idx <= t, out_valid <= 1, t <= t+1.
REQ-016 LOAD with no accepted word and adv=1: out_valid <= 0.
REQ-017 LOAD -> EXPAND when the word with t=15 is accepted.
REQ-018 EXPAND (t 16..63): in_ready = 0; on adv: compute W = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], all read from buf at index (t-k) mod 16; buf[t[3:0]] <= W; out_data <= W; out_idx <= t; out_valid <= 1; t <= t+1.
REQ-019 sig0(x) = ror7 ^ ror18 ^ shr3; sig1(x) = ror17 ^ ror19 ^ shr10; 32-bit rotates/logical shifts.
REQ-020 Additions modulo 2^32; carries out of bit 31 discarded.
REQ-021 EXPAND -> LOAD when W[63] is issued; t wraps 63 -> 0; next block's M[0] may be accepted the following cycle (no bubble).
REQ-022 Latency: word accepted/computed on edge N is visible on out_data with out_valid=1 after edge N; with out_ready=1 and continuous in_valid, one word per cycle, 64 cycles per block.
REQ-023 Reads of buf in EXPAND use values written on earlier edges only; W[t] written on edge N is readable for W[t+2] on edge N+2 and later.
REQ-024 clear=1: t <= 0, state <= LOAD, out_valid <= 0, in_ready = 0 that cycle; clear overrides simultaneous in_valid and adv.
REQ-025 in_data ignored whenever in_ready=0; out_ready ignored when out_valid=0.
REQ-026 Output stream strictly in order W[0]..W[63]; no index skipped or repeated.

Reset
REQ-027 rst=1 at edge: state <= LOAD, t <= 0, out_valid <= 0, out_data <= 0, out_idx <= 0; rst overrides clear and all handshakes.
REQ-028 During rst=1 cycle in_ready = 0; busy = 0 after reset edge.
REQ-029 buf contents not reset; no output depends on buf before it is written in the current block.
REQ-030 rst or clear mid-block discards the partial block; next accepted word is treated as M[0].

Verification
REQ-031 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), out_ready=1 -> out_idx 0..63 consecutive, W16=0x61626380, W17=0x000F0000, W18..W63 match FIPS 180-4 golden model.
REQ-032 Backpressure: out_ready=0 for 5 cycles while out_idx=20 -> out_data/out_idx/out_valid stable, t not advanced, W21 correct after release.
REQ-033 Input gaps: in_valid toggled randomly during LOAD -> out_valid low in idle cycles, W0..W15 equal inputs in order, expansion identical to REQ-031.
REQ-034 Two blocks back-to-back with in_valid=1 -> second M0 accepted the cycle after W63 issued, 128 words in 128 cycles, both schedules correct.
REQ-035 clear asserted at out_idx=40, same cycle in_valid=1 -> word not accepted, out_valid=0 next cycle, following block produces correct W0..W63.
REQ-036 rst asserted during EXPAND -> all outputs 0 and busy=0 after edge; fresh block afterward correct.
